dso_capture_ctrl: RTL and testbench
===================================

# dso_capture_ctrl

Capture controller for the DSO sample path: sequences one acquisition into a circular sample RAM around a trigger event. It is the counterpart of the trigger detector. It drives `armed` and `trig_en` to that block, consumes its `triggered` level, and issues the one-cycle `set_capture_done` that clears it. It generates RAM write enable and address, and reports where the trace ends so readback can unwrap the buffer.

## Interface
Parameters:
- ADDR_W, 9, sample RAM address width; DEPTH = 2**ADDR_W entries.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  start-acquisition pulse; honoured only in IDLE
- clr_cap_done  in  1  acknowledge; returns DONE to IDLE
- cap_en  in  1  sample strobe from decimator; one sample per high cycle
- trig_pos  in  ADDR_W  post-trigger sample count; sampled at `run`
- triggered  in  1  trigger-detector output; level, held until `set_capture_done`
- trig_en  out  1  trigger detector enable
- armed  out  1  pre-trigger region full; trigger may be accepted
- we  out  1  sample RAM write enable
- waddr  out  ADDR_W  sample RAM write address
- set_capture_done  out  1  one-cycle pulse at end of capture
- capture_done  out  1  status flag; set with the pulse, cleared by `clr_cap_done`
- trace_end  out  ADDR_W  address of the last sample written in the completed capture

## Operation
- States are IDLE, PRE, ARMED, POST and DONE. Reset enters IDLE.
- **IDLE**
  - On `run`, latch `trig_pos` into `tp`.
  - Clear `waddr`, `smp_cnt` and `post_cnt`.
  - Go to PRE.
- **PRE**
  - Each `cap_en` writes at `waddr`, then increments `waddr` and `smp_cnt`.
  - When a write makes `smp_cnt` equal DEPTH − `tp`, go to ARMED.
  - `triggered` is ignored.
- **ARMED**
  - Writes continue; `smp_cnt` saturates and is unused.
  - When `triggered` = 1, go to POST. A `cap_en` in that same cycle is written as a pre-trigger sample.
- **POST**
  - If `post_cnt` = `tp`, go to DONE and perform no write that cycle.
  - Otherwise each `cap_en` writes at `waddr` and increments `waddr` and `post_cnt`.
- **DONE**
  - No writes.
  - `clr_cap_done` returns to IDLE.
  - `run` is ignored until the return to IDLE.
- Combinational outputs:
  - `we` = `cap_en` & (PRE | ARMED | (POST & `post_cnt` ≠ `tp`)).
  - `trig_en` = PRE | ARMED | POST.
- `waddr` wraps DEPTH−1 → 0 using modulo-DEPTH arithmetic.
- `armed` is registered. It is 1 exactly while in ARMED or POST.
- On the POST→DONE transition, in the same cycle:
  - `set_capture_done` pulses for one cycle.
  - `capture_done` is set.
  - `trace_end` loads `waddr` − 1 (mod DEPTH).
- `tp` = 0: POST exits on its first cycle with no post-trigger samples.
- `tp` max = DEPTH−1: one pre-trigger sample is required before arming.
- `run` or `clr_cap_done` outside its own state has no effect.
- If `run` and `clr_cap_done` are high together in DONE, only the clear acts. IDLE is entered and the run is dropped.
- `rst_n` low mid-capture returns to IDLE immediately. Partial data is abandoned.

## Timing
- Reset values:
  - state IDLE.
  - `waddr`, `trace_end`, counters and `tp` all 0.
  - `armed`, `capture_done` and `set_capture_done` 0.
  - `we` and `trig_en` 0.
- `run` at edge N: state is PRE after edge N. The first write can occur in cycle N+1.
- Write address timing: `we` and `waddr` are valid in the same cycle. `waddr` advances at the edge that ends that cycle.
- The write that completes the pre-trigger region is at edge M. Then ARMED and `armed` are 1 after edge M.
- With the trigger detector's 3-flop synchroniser, `triggered` rises ≥4 cycles after the source edge. This block adds 1 cycle (ARMED→POST).
- After the `tp`-th post write at edge P, the POST→DONE edge is P+1. `set_capture_done` is high in cycle P+1. `triggered` falls one cycle later.

## Test plan
- ADDR_W=3, `tp`=3, `cap_en` tied 1, `run`:
  - `armed` rises after 5 writes (addrs 0–4).
  - Raise `triggered` at addr 6 → 1 more write in ARMED, then 3 post writes (addrs 7, 0, 1).
  - `set_capture_done` pulses once; `trace_end`=1; `capture_done`=1.
- `tp`=0:
  - Once `triggered` is seen, the next cycle pulses `set_capture_done`.
  - No POST writes; `trace_end` = last ARMED address.
- `triggered` held 1 from `run` onward → no transition before `armed`. POST entered the cycle after arming.
- Sparse `cap_en` (1 in 4) → `we` only on strobes, `waddr` wraps 7→0. Count correct across the wrap.
- `rst_n` asserted in POST → all outputs at reset values asynchronously. A new `run` starts at `waddr`=0.
- In DONE:
  - `run` alone → ignored.
  - `run` + `clr_cap_done` together → IDLE, `capture_done`=0, no PRE entry.
  - A following `run` starts a capture.

Source files
------------

// File: rtl/dso_capture_ctrl.sv
// Capture controller for the DSO sample path: sequences one acquisition into a
// circular sample RAM around a trigger and reports where the trace ends.
module dso_capture_ctrl #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              clr_cap_done,
    input  logic              cap_en,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              triggered,
    output logic              trig_en,
    output logic              armed,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              set_capture_done,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trace_end
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] tp;
    logic [ADDR_W-1:0] post_cnt;
    logic [CNT_W-1:0]  smp_cnt;

    logic              post_full_c;
    logic [CNT_W-1:0]  smp_next_c;
    logic [CNT_W-1:0]  pre_target_c;

    // Pre-trigger region is DEPTH - tp samples; counter is one bit wider so DEPTH fits.
    assign post_full_c  = (post_cnt == tp);
    assign smp_next_c   = smp_cnt + CNT_W'(1);
    assign pre_target_c = CNT_W'(DEPTH) - {1'b0, tp};

    assign we      = cap_en & ((state == S_PRE) || (state == S_ARMED) ||
                               ((state == S_POST) && !post_full_c));
    assign trig_en = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);

    // Acquisition sequencer; waddr wraps naturally at ADDR_W bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            tp               <= '0;
            post_cnt         <= '0;
            smp_cnt          <= '0;
            waddr            <= '0;
            trace_end        <= '0;
            armed            <= 1'b0;
            capture_done     <= 1'b0;
            set_capture_done <= 1'b0;
        end else begin
            set_capture_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        tp       <= trig_pos;
                        waddr    <= '0;
                        smp_cnt  <= '0;
                        post_cnt <= '0;
                        state    <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (cap_en) begin
                        waddr   <= waddr + ADDR_W'(1);
                        smp_cnt <= smp_next_c;
                        if (smp_next_c == pre_target_c) begin
                            state <= S_ARMED;
                            armed <= 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    if (cap_en) begin
                        waddr <= waddr + ADDR_W'(1);
                    end
                    if (triggered) begin
                        state <= S_POST;
                    end
                end
                S_POST: begin
                    if (post_full_c) begin
                        state            <= S_DONE;
                        armed            <= 1'b0;
                        set_capture_done <= 1'b1;
                        capture_done     <= 1'b1;
                        trace_end        <= waddr - ADDR_W'(1);
                    end else if (cap_en) begin
                        waddr    <= waddr + ADDR_W'(1);
                        post_cnt <= post_cnt + ADDR_W'(1);
                    end
                end
                S_DONE: begin
                    // A clear wins over a simultaneous run; the run is dropped.
                    if (clr_cap_done) begin
                        state        <= S_IDLE;
                        capture_done <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dso_capture_ctrl.sv
// Directed bench for dso_capture_ctrl with an 8-entry buffer.
module tb_dso_capture_ctrl;

    localparam int unsigned AW = 3;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic          clr_cap_done;
    logic          cap_en;
    logic [AW-1:0] trig_pos;
    logic          triggered;
    logic          trig_en;
    logic          armed;
    logic          we;
    logic [AW-1:0] waddr;
    logic          set_capture_done;
    logic          capture_done;
    logic [AW-1:0] trace_end;

    int n_checks = 0;
    int n_err    = 0;
    int n_pulses = 0;

    dso_capture_ctrl #(.ADDR_W(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .run              (run),
        .clr_cap_done     (clr_cap_done),
        .cap_en           (cap_en),
        .trig_pos         (trig_pos),
        .triggered        (triggered),
        .trig_en          (trig_en),
        .armed            (armed),
        .we               (we),
        .waddr            (waddr),
        .set_capture_done (set_capture_done),
        .capture_done     (capture_done),
        .trace_end        (trace_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (set_capture_done) n_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One strobe cycle followed by three idle cycles.
    task automatic sparse_write(input logic [AW-1:0] addr);
        cap_en = 1'b1;
        #1;
        chk1("sparse_we", we, 1'b1);
        chka("sparse_waddr", waddr, addr);
        step();
        cap_en = 1'b0;
        #1;
        chk1("sparse_idle_we", we, 1'b0);
        step();
        step();
        step();
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; clr_cap_done = 1'b0; cap_en = 1'b0;
        trig_pos = '0; triggered = 1'b0;
        #1;
        chka("rst_waddr", waddr, 3'd0);
        chka("rst_trace_end", trace_end, 3'd0);
        chk1("rst_armed", armed, 1'b0);
        chk1("rst_we", we, 1'b0);
        chk1("rst_trig_en", trig_en, 1'b0);
        chk1("rst_cap_done", capture_done, 1'b0);
        chk1("rst_scd", set_capture_done, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Basic capture, tp=3, continuous strobe
        run = 1'b1; trig_pos = 3'd3; cap_en = 1'b1;
        #1;
        chk1("idle_we", we, 1'b0);
        chk1("idle_trig_en", trig_en, 1'b0);
        step();
        run = 1'b0;
        #1;
        chk1("pre_trig_en", trig_en, 1'b1);
        chk1("pre_we", we, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chka("pre_waddr", waddr, 3'(i));
            chk1("pre_armed", armed, 1'b0);
            step();
        end
        chk1("armed_rise", armed, 1'b1);
        chka("armed_waddr", waddr, 3'd5);
        step();
        triggered = 1'b1;
        #1;
        chka("trig_waddr", waddr, 3'd6);
        chk1("trig_cycle_we", we, 1'b1);
        step();
        for (int j = 0; j < 3; j++) begin
            chka("post_waddr", waddr, 3'(7 + j));
            chk1("post_we", we, 1'b1);
            chk1("post_armed", armed, 1'b1);
            step();
        end
        chk1("post_full_we", we, 1'b0);
        chk1("post_full_scd", set_capture_done, 1'b0);
        chk1("post_full_trig_en", trig_en, 1'b1);
        step();
        chk1("done_scd", set_capture_done, 1'b1);
        chk1("done_cap_done", capture_done, 1'b1);
        chka("done_trace_end", trace_end, 3'd1);
        chk1("done_armed", armed, 1'b0);
        chk1("done_we", we, 1'b0);
        chk1("done_trig_en", trig_en, 1'b0);
        triggered = 1'b0;
        step();
        chk1("scd_one_cycle", set_capture_done, 1'b0);
        chkn("pulses_1", n_pulses, 1);

        // run alone in DONE is ignored
        run = 1'b1;
        step();
        run = 1'b0;
        #1;
        chk1("done_run_cap_done", capture_done, 1'b1);
        chk1("done_run_trig_en", trig_en, 1'b0);
        chka("done_run_waddr", waddr, 3'd2);
        // run + clear together: clear only
        run = 1'b1; clr_cap_done = 1'b1;
        step();
        run = 1'b0; clr_cap_done = 1'b0;
        #1;
        chk1("clr_cap_done", capture_done, 1'b0);
        chk1("clr_no_pre", trig_en, 1'b0);
        step();
        chk1("clr_still_idle", trig_en, 1'b0);

        // tp=0: trigger ends the capture with no post samples
        run = 1'b1; trig_pos = 3'd0; cap_en = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk1("tp0_not_armed", armed, 1'b0);
        step();
        chk1("tp0_armed", armed, 1'b1);
        chka("tp0_wrap", waddr, 3'd0);
        step();
        triggered = 1'b1;
        step();
        #1;
        chk1("tp0_post_we", we, 1'b0);
        chka("tp0_post_waddr", waddr, 3'd2);
        step();
        chk1("tp0_scd", set_capture_done, 1'b1);
        chka("tp0_trace_end", trace_end, 3'd1);
        chk1("tp0_cap_done", capture_done, 1'b1);
        triggered = 1'b0; clr_cap_done = 1'b1;
        step();
        clr_cap_done = 1'b0;
        chkn("pulses_2", n_pulses, 2);

        // triggered held from run: ignored until armed
        run = 1'b1; trig_pos = 3'd6; triggered = 1'b1;
        step();
        run = 1'b0;
        chk1("hold_pre0_armed", armed, 1'b0);
        step();
        chk1("hold_pre1_armed", armed, 1'b0);
        chka("hold_pre1_waddr", waddr, 3'd1);
        step();
        chk1("hold_armed", armed, 1'b1);
        chka("hold_armed_waddr", waddr, 3'd2);
        step();
        for (int k = 0; k < 6; k++) begin
            chk1("hold_post_we", we, 1'b1);
            chka("hold_post_waddr", waddr, 3'(3 + k));
            step();
        end
        chk1("hold_full_we", we, 1'b0);
        step();
        chk1("hold_scd", set_capture_done, 1'b1);
        chka("hold_trace_end", trace_end, 3'd0);
        triggered = 1'b0; clr_cap_done = 1'b1;
        step();
        clr_cap_done = 1'b0;
        chkn("pulses_3", n_pulses, 3);

        // Sparse strobe, tp=4, wraps during POST
        run = 1'b1; trig_pos = 3'd4; cap_en = 1'b0;
        step();
        run = 1'b0;
        for (int i = 0; i < 4; i++) sparse_write(3'(i));
        chk1("sparse_armed", armed, 1'b1);
        sparse_write(3'd4);
        sparse_write(3'd5);
        triggered = 1'b1;
        step();
        chka("sparse_post_entry", waddr, 3'd6);
        sparse_write(3'd6);
        sparse_write(3'd7);
        sparse_write(3'd0);
        sparse_write(3'd1);
        chk1("sparse_cap_done", capture_done, 1'b1);
        chka("sparse_trace_end", trace_end, 3'd1);
        chk1("sparse_done_armed", armed, 1'b0);
        triggered = 1'b0; clr_cap_done = 1'b1;
        step();
        clr_cap_done = 1'b0;
        chkn("pulses_4", n_pulses, 4);

        // Asynchronous reset in POST
        run = 1'b1; trig_pos = 3'd3; cap_en = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 5; i++) step();
        triggered = 1'b1;
        step();
        chk1("rstpost_armed_pre", armed, 1'b1);
        chka("rstpost_waddr_pre", waddr, 3'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst_armed", armed, 1'b0);
        chka("arst_waddr", waddr, 3'd0);
        chk1("arst_trig_en", trig_en, 1'b0);
        chk1("arst_we", we, 1'b0);
        chka("arst_trace_end", trace_end, 3'd0);
        chk1("arst_cap_done", capture_done, 1'b0);
        rst_n = 1'b1; triggered = 1'b0;
        step();
        run = 1'b1;
        step();
        run = 1'b0;
        #1;
        chka("rerun_waddr", waddr, 3'd0);
        chk1("rerun_we", we, 1'b1);
        chk1("rerun_trig_en", trig_en, 1'b1);
        step();
        chka("rerun_waddr1", waddr, 3'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
